// File: rtl/pwm_monitor.sv
// ============================================================================
// pwm_monitor - half-bridge gate timing monitor: period, on-time, dead time,
// shoot-through fault and stall detection.                        Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pwm_monitor #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hs,
  input  logic         ls,
  input  logic         clr,
  output logic [W-1:0] period,
  output logic [W-1:0] on_time,
  output logic [W-1:0] dead,
  output logic         valid,
  output logic         fault,
  output logic         stall
);

  localparam logic [W-1:0] c_MAX     = '1;
  localparam logic [W-1:0] c_ONE     = W'(1);
  localparam logic [W-1:0] c_TIMEOUT = W'(TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_hs_m;
  logic         r_hs_s;
  logic         r_hs_d;
  logic         r_ls_m;
  logic         r_ls_s;

  logic [W-1:0] r_per_cnt;
  logic [W-1:0] r_on_cnt;
  logic [W-1:0] r_dead_cnt;

  logic [W-1:0] r_period;
  logic [W-1:0] r_on_time;
  logic [W-1:0] r_dead;
  logic         r_valid;
  logic         r_fault;
  logic         r_stall;

  logic         w_rise;
  logic         w_overlap;
  logic         w_load;
  logic         w_latch;
  logic         w_timeout;

  function automatic logic [W-1:0] f_sat_inc(input logic [W-1:0] v);
    return (v == c_MAX) ? v : v + c_ONE;
  endfunction

  // hs/ls are asynchronous to clk; hs gets a third stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_m <= 1'b0;
      r_hs_s <= 1'b0;
      r_hs_d <= 1'b0;
      r_ls_m <= 1'b0;
      r_ls_s <= 1'b0;
    end else begin
      r_hs_m <= hs;
      r_hs_s <= r_hs_m;
      r_hs_d <= r_hs_s;
      r_ls_m <= ls;
      r_ls_s <= r_ls_m;
    end
  end

  assign w_rise    = r_hs_s & ~r_hs_d;
  assign w_overlap = r_hs_s & r_ls_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A rise always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_rise) begin
          w_load  = 1'b1;
          w_latch = 1'b1;
        end else if (r_per_cnt == c_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The rise cycle itself counts as one period cycle and one on cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_cnt  <= '0;
      r_on_cnt   <= '0;
      r_dead_cnt <= '0;
    end else if (w_load) begin
      r_per_cnt  <= c_ONE;
      r_on_cnt   <= c_ONE;
      r_dead_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_per_cnt <= f_sat_inc(r_per_cnt);
      if (r_hs_s) begin
        r_on_cnt <= f_sat_inc(r_on_cnt);
      end
      if (!r_hs_s && !r_ls_s) begin
        r_dead_cnt <= f_sat_inc(r_dead_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period  <= '0;
      r_on_time <= '0;
      r_dead    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_latch;
      if (w_latch) begin
        r_period  <= r_per_cnt;
        r_on_time <= r_on_cnt;
        r_dead    <= r_dead_cnt;
      end else if (w_timeout) begin
        r_period  <= '0;
        r_on_time <= '0;
        r_dead    <= '0;
      end
    end
  end

  // Sticky flags: a set condition overrides a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      if (w_overlap) begin
        r_fault <= 1'b1;
      end else if (clr) begin
        r_fault <= 1'b0;
      end
      if (w_timeout) begin
        r_stall <= 1'b1;
      end else if (clr) begin
        r_stall <= 1'b0;
      end
    end
  end

  assign period  = r_period;
  assign on_time = r_on_time;
  assign dead    = r_dead;
  assign valid   = r_valid;
  assign fault   = r_fault;
  assign stall   = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_pwm_monitor.sv
// ============================================================================
// tb_pwm_monitor - scoreboard bench for pwm_monitor (default and W=8 builds).
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_monitor;

  localparam int W   = 16;
  localparam int TO  = 1000;
  localparam int W2  = 8;
  localparam int TO2 = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          hs, ls, clr;
  logic          hs2, ls2, clr2;
  logic [W-1:0]  period, on_time, dead;
  logic          valid, fault, stall;
  logic [W2-1:0] period2, on_time2, dead2;
  logic          valid2, fault2, stall2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int per;
    int on;
    int dd;
  } res_t;

  res_t q1[$];
  res_t q2[$];
  res_t prev1, prev2;
  bit   have1, have2;

  always #5 clk = ~clk;

  pwm_monitor #(.W(W), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .hs(hs), .ls(ls), .clr(clr),
    .period(period), .on_time(on_time), .dead(dead),
    .valid(valid), .fault(fault), .stall(stall)
  );

  pwm_monitor #(.W(W2), .TIMEOUT(TO2)) u_dut8 (
    .clk(clk), .rst(rst), .hs(hs2), .ls(ls2), .clr(clr2),
    .period(period2), .on_time(on_time2), .dead(dead2),
    .valid(valid2), .fault(fault2), .stall(stall2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitors: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b1 && valid === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut16 unexpected valid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut16 period", 32'(period), e.per);
        chk("dut16 on_time", 32'(on_time), e.on);
        chk("dut16 dead", 32'(dead), e.dd);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b1 && valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("dut8 unexpected valid", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("dut8 period", 32'(period2), e.per);
        chk("dut8 on_time", 32'(on_time2), e.on);
        chk("dut8 dead", 32'(dead2), e.dd);
      end
    end
  end

  // One switching period on the 16-bit instance; hs high for cycles 0..hlen-1,
  // ls high for cycles ls_a..ls_b. Optional clr pulse with a flag check after it.
  task automatic wave(input int p, input int hlen, input int ls_a, input int ls_b,
                      input int exp_on, input int exp_dead,
                      input int clr_at, input bit exp_f, input bit exp_st);
    if (have1) q1.push_back(prev1);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      if (clr_at >= 0 && c == clr_at + 1) begin
        chk("fault after clr", 32'(fault), 32'(exp_f));
        chk("stall after clr", 32'(stall), 32'(exp_st));
      end
      hs  = (c < hlen);
      ls  = (c >= ls_a && c <= ls_b);
      clr = (c == clr_at);
    end
    prev1 = '{p, exp_on, exp_dead};
    have1 = 1'b1;
  endtask

  task automatic wave2(input int p, input int hlen, input int exp_on, input int exp_dead);
    if (have2) q2.push_back(prev2);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      hs2 = (c < hlen);
    end
    prev2 = '{p, exp_on, exp_dead};
    have2 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hs  = 1'b0;
      ls  = 1'b0;
      clr = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; hs = 1'b0; ls = 1'b0; clr = 1'b0;
    hs2 = 1'b0; ls2 = 1'b0; clr2 = 1'b0;
    have1 = 1'b0; have2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset period", 32'(period), 0);
    chk("reset on_time", 32'(on_time), 0);
    chk("reset dead", 32'(dead), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset fault", 32'(fault), 0);
    chk("reset stall", 32'(stall), 0);
    rst = 1'b1;
    idle(3);

    // Nominal: P=201, on 100, dead 3+3
    repeat (4) wave(201, 100, 103, 197, 100, 6, -1, 1'b0, 1'b0);
    chk("nominal fault", 32'(fault), 0);

    // Overlap cycles 95..99: fault lands two cycles after first overlap sample
    wave(201, 100, 95, 197, 100, 3, 96, 1'b0, 1'b0);
    wave(201, 100, 95, 197, 100, 3, 150, 1'b0, 1'b0);
    wave(201, 100, 95, 197, 100, 3, 97, 1'b1, 1'b0);
    chk("overlap fault sticky", 32'(fault), 1);
    wave(201, 100, 103, 197, 100, 6, 50, 1'b0, 1'b0);

    // Stall: last rise, then hs low; timeout lands 1002 edges after the rise sample
    wave(201, 100, 103, 197, 100, 6, -1, 1'b0, 1'b0);
    have1 = 1'b0;
    idle(802);
    chk("stall before timeout", 32'(stall), 0);
    @(negedge clk);
    chk("stall set", 32'(stall), 1);
    chk("stall period", 32'(period), 0);
    chk("stall on_time", 32'(on_time), 0);
    chk("stall dead", 32'(dead), 0);

    // Restart: clr drops stall, first rise silent, then normal results
    wave(201, 100, 103, 197, 100, 6, 50, 1'b0, 1'b0);
    repeat (2) wave(201, 100, 103, 197, 100, 6, -1, 1'b0, 1'b0);

    // Async reset at cycle 50 of a period, hs still high at release
    wave(50, 50, 1, 0, 50, 0, -1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst period", 32'(period), 0);
    chk("async rst on_time", 32'(on_time), 0);
    chk("async rst dead", 32'(dead), 0);
    chk("async rst valid", 32'(valid), 0);
    chk("async rst fault", 32'(fault), 0);
    chk("async rst stall", 32'(stall), 0);
    have1 = 1'b0;
    repeat (2) @(negedge clk);
    fork
      begin
        @(negedge clk);
        rst = 1'b1;
      end
    join_none
    repeat (3) wave(201, 100, 103, 197, 100, 6, -1, 1'b0, 1'b0);

    // Minimum period and zero duty
    repeat (4) wave(2, 1, 1, 0, 1, 1, -1, 1'b0, 1'b0);
    have1 = 1'b0;
    idle(1010);
    chk("duty0 stall", 32'(stall), 1);
    chk("duty0 period", 32'(period), 0);
    chk("duty0 fault", 32'(fault), 0);

    // 8-bit instance: near-full-scale periods, then a 300-cycle gap times out at 255
    repeat (2) wave2(250, 249, 249, 1);
    wave2(300, 299, 299, 0);
    chk("dut8 stall", 32'(stall2), 1);
    chk("dut8 stall period", 32'(period2), 0);
    chk("dut8 stall on_time", 32'(on_time2), 0);
    have2 = 1'b0;
    wave2(10, 5, 5, 5);
    repeat (5) @(negedge clk);
    chk("dut8 restart period", 32'(period2), 0);
    chk("dut8 fault", 32'(fault2), 0);

    chk("dut16 pending results", 32'(q1.size()), 0);
    chk("dut8 pending results", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
